uart_rx_fifo: RTL

Parametrised UART receiver, next generation of the existing fixed 8N1 receiver.
- Adds configurable data width, parity mode, runtime baud divisor, false-start rejection, and per-word parity/framing error flags.
- Adds an internal first-word-fall-through RX FIFO with sticky overrun.
- Sits between the external RX pin and the CPU-side MMIO/Decoupled consumer.

---
 rtl/uart_rx_fifo.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver with a first-word-fall-through RX FIFO and sticky overrun flag.
// Defining UART_RX_BREAK_DETECT_EN turns all-zero frames with a low stop bit into o_break pulses.
module uart_rx_fifo #(
    parameter int DataBits     = 8,
    parameter int Parity       = 0,
    parameter int FifoDepth    = 4,
    parameter int RxSyncStages = 2,
    parameter int DivWidth     = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [DivWidth-1:0]            i_div,
    input  logic                           i_rx,
    output logic                           o_dout_valid,
    input  logic                           i_dout_ready,
    output logic [DataBits-1:0]            o_dout_bits,
    output logic                           o_dout_perr,
    output logic                           o_dout_ferr,
    output logic                           o_overrun,
    input  logic                           i_clr_overrun,
    output logic [$clog2(FifoDepth+1)-1:0] o_level,
    output logic                           o_busy,
    output logic                           o_break
);
    localparam int PtrW  = $clog2(FifoDepth);
    localparam int LvlW  = $clog2(FifoDepth + 1);
    localparam int IdxW  = $clog2(DataBits);
    localparam int WordW = DataBits + 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_WAIT   = 3'd5;

    localparam logic [DivWidth-1:0] DivOne  = {{(DivWidth-1){1'b0}}, 1'b1};
    localparam logic [IdxW-1:0]     IdxOne  = {{(IdxW-1){1'b0}}, 1'b1};
    localparam logic [IdxW-1:0]     IdxLast = IdxW'(DataBits - 1);
    localparam logic [PtrW-1:0]     PtrOne  = {{(PtrW-1){1'b0}}, 1'b1};
    localparam logic [LvlW-1:0]     LvlOne  = {{(LvlW-1){1'b0}}, 1'b1};
    localparam logic [LvlW-1:0]     LvlFull = LvlW'(FifoDepth);

    function automatic logic parity_err(input logic [DataBits-1:0] data, input logic par_bit);
        logic even_err;
        even_err = (^data) ^ par_bit;
        return (Parity == 2) ? ~even_err : even_err;
    endfunction

    logic [RxSyncStages-1:0] sync_q;
    logic                    rx_prev_q;
    logic                    s_rx;
    logic                    edge_s;
    logic                    sample_s;
    logic [2:0]              state_q, state_d;
    logic [DivWidth-1:0]     div_q, div_d;
    logic [DivWidth-1:0]     cnt_q, cnt_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [DataBits-1:0]     data_q, data_d;
    logic                    perr_q, perr_d;
    logic                    push_s, ferr_s, brk_s;

    logic [WordW-1:0]        mem_q [FifoDepth];
    logic [WordW-1:0]        head_s;
    logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0]         level_q;
    logic                    ovr_q, brk_q;
    logic                    full_s, pop_s, wr_en_s, ovr_set_s;

    assign s_rx     = sync_q[RxSyncStages-1];
    assign edge_s   = rx_prev_q & ~s_rx;
    assign sample_s = (cnt_q == {DivWidth{1'b0}});

`ifdef UART_RX_BREAK_DETECT_EN
    logic par_low_s, is_brk_s;
    // With all-zero data the received parity bit follows directly from the parity error flag.
    assign par_low_s = (Parity == 0) ? 1'b1 : ((Parity == 2) ? perr_q : ~perr_q);
    assign is_brk_s  = (data_q == {DataBits{1'b0}}) & par_low_s & ~s_rx;
`endif

    // Input synchroniser (resets to idle-high) and edge-detect history.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q    <= {RxSyncStages{1'b1}};
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[RxSyncStages-2:0], i_rx};
            rx_prev_q <= s_rx;
        end
    end

    // Receiver next-state: bit timing, sampling and push/break requests.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        perr_d  = perr_q;
        push_s  = 1'b0;
        ferr_s  = 1'b0;
        brk_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (edge_s) begin
                    div_d   = i_div;
                    cnt_d   = (i_div >> 1) - DivOne;
                    idx_d   = {IdxW{1'b0}};
                    perr_d  = 1'b0;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (s_rx) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_START, ST_DATA, ST_PARITY, ST_STOP: begin
                if (!sample_s) begin
                    cnt_d = cnt_q - DivOne;
                end else begin
                    cnt_d = div_q - DivOne;
                    case (state_q)
                        ST_START: state_d = s_rx ? ST_IDLE : ST_DATA;
                        ST_DATA: begin
                            data_d = {s_rx, data_q[DataBits-1:1]};
                            idx_d  = idx_q + IdxOne;
                            if (idx_q == IdxLast) begin
                                state_d = (Parity != 0) ? ST_PARITY : ST_STOP;
                            end else begin
                                state_d = ST_DATA;
                            end
                        end
                        ST_PARITY: begin
                            perr_d  = parity_err(data_q, s_rx);
                            state_d = ST_STOP;
                        end
                        ST_STOP: begin
                            ferr_s = ~s_rx;
`ifdef UART_RX_BREAK_DETECT_EN
                            if (is_brk_s) begin
                                brk_s   = 1'b1;
                                state_d = ST_WAIT;
                            end else begin
                                push_s  = 1'b1;
                                state_d = s_rx ? ST_IDLE : ST_WAIT;
                            end
`else
                            push_s  = 1'b1;
                            state_d = s_rx ? ST_IDLE : ST_WAIT;
`endif
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Receiver state registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            div_q   <= {DivWidth{1'b0}};
            cnt_q   <= {DivWidth{1'b0}};
            idx_q   <= {IdxW{1'b0}};
            data_q  <= {DataBits{1'b0}};
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
        end
    end

    assign pop_s     = (level_q != {LvlW{1'b0}}) & i_dout_ready;
    assign full_s    = (level_q == LvlFull);
    assign wr_en_s   = push_s & (~full_s | pop_s);
    assign ovr_set_s = push_s & full_s & ~pop_s;

    // FIFO storage, pointers, occupancy, sticky overrun and break pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < FifoDepth; i++) begin
                mem_q[i] <= {WordW{1'b0}};
            end
            wr_ptr_q <= {PtrW{1'b0}};
            rd_ptr_q <= {PtrW{1'b0}};
            level_q  <= {LvlW{1'b0}};
            ovr_q    <= 1'b0;
            brk_q    <= 1'b0;
        end else begin
            if (wr_en_s) begin
                mem_q[wr_ptr_q] <= {data_q, perr_q, ferr_s};
                wr_ptr_q        <= wr_ptr_q + PtrOne;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
            case ({wr_en_s, pop_s})
                2'b10:   level_q <= level_q + LvlOne;
                2'b01:   level_q <= level_q - LvlOne;
                default: level_q <= level_q;
            endcase
            // A set in the same cycle as a clear must win.
            if (ovr_set_s) begin
                ovr_q <= 1'b1;
            end else if (i_clr_overrun) begin
                ovr_q <= 1'b0;
            end
            brk_q <= brk_s;
        end
    end

    assign head_s       = mem_q[rd_ptr_q];
    assign o_dout_valid = (level_q != {LvlW{1'b0}});
    assign o_dout_bits  = head_s[WordW-1:2];
    assign o_dout_perr  = head_s[1];
    assign o_dout_ferr  = head_s[0];
    assign o_overrun    = ovr_q;
    assign o_level      = level_q;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_break      = brk_q;
endmodule
